// File: rtl/uart_mmio_pkg.sv
// Shared register map constants and decode helper for the UART rx MMIO controller.
package uart_mmio_pkg;

    localparam logic [15:0] DATA_OFS = 16'd0;
    localparam logic [15:0] STAT_OFS = 16'd1;
    localparam logic [15:0] CTRL_OFS = 16'd2;

    localparam int unsigned ST_NE      = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_OVR     = 2;
    localparam int unsigned ST_CNT_LSB = 3;

    localparam int unsigned CT_IRQEN = 0;
    localparam int unsigned CT_FLUSH = 1;

    localparam int unsigned DATA_VALID_BIT = 15;

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_STAT = 2'd1,
        REG_CTRL = 2'd2,
        REG_NONE = 2'd3
    } reg_sel_e;

    // Map a word offset from the base address onto a register select.
    function automatic reg_sel_e decode_ofs(input logic [15:0] ofs);
        reg_sel_e sel;
        sel = REG_NONE;
        if (ofs == DATA_OFS) sel = REG_DATA;
        else if (ofs == STAT_OFS) sel = REG_STAT;
        else if (ofs == CTRL_OFS) sel = REG_CTRL;
        return sel;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with occupancy count; pop gated by !empty, push accepted when a slot is free or frees this cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             pop_ok;
    logic             push_ok;

    // Next-state for storage, pointers and flags; flush overrides any push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty_q;
        push_ok  = push & (~full_q | pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop_ok) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            count_d = CNT_W'(count_q + CNT_W'(push_ok) - CNT_W'(pop_ok));
        end
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // State registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_rx_mmio_ctrl.sv
// CPU-facing register block buffering UART rx bytes, with overrun tracking and level interrupt.
module uart_rx_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    input  logic [15:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_hit,
    output logic        irq
);

    logic [15:0]      rd_data_q, rd_data_d;
    logic             rd_hit_q, rd_hit_d;
    logic             irq_q, irq_d;
    logic             irq_en_q, irq_en_d;
    logic             ovr_q, ovr_d;

    reg_sel_e         sel;
    logic             pop_req;
    logic             pop_ok;
    logic             wr_stat;
    logic             wr_ctrl;
    logic             flush;
    logic             ovr_set;
    logic             ovr_clr;
    logic [15:0]      stat_word;

    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_wr_bits;

    assign unused_wr_bits = ^wr_data[15:3];

    // Address decode and write/pop strobes.
    always_comb begin
        sel     = decode_ofs(16'(addr - BASE_ADDR));
        pop_req = rd_en & (sel == REG_DATA);
        pop_ok  = pop_req & ~fifo_empty;
        wr_stat = wr_en & (sel == REG_STAT);
        wr_ctrl = wr_en & (sel == REG_CTRL);
        flush   = wr_ctrl & wr_data[CT_FLUSH];
        ovr_set = rx_valid & fifo_full & ~pop_ok & ~flush;
        ovr_clr = (wr_stat & wr_data[ST_OVR]) | flush;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_valid),
        .pop   (pop_req),
        .flush (flush),
        .din   (rx_byte),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Status word assembled from current (pre-edge) state.
    always_comb begin
        stat_word                           = '0;
        stat_word[ST_NE]                    = ~fifo_empty;
        stat_word[ST_FULL]                  = fifo_full;
        stat_word[ST_OVR]                   = ovr_q;
        stat_word[ST_CNT_LSB +: CNT_W]      = fifo_count;
    end

    // Control/overrun/irq next state and registered read mux.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_hit_d  = 1'b0;
        irq_en_d  = irq_en_q;
        ovr_d     = ovr_q;

        if (wr_ctrl) irq_en_d = wr_data[CT_IRQEN];
        if (ovr_clr) ovr_d = 1'b0;
        if (ovr_set) ovr_d = 1'b1;

        if (rd_en && (sel != REG_NONE)) begin
            rd_hit_d = 1'b1;
            unique case (sel)
                REG_DATA: begin
                    rd_data_d = '0;
                    if (!fifo_empty) begin
                        rd_data_d[DATA_VALID_BIT] = 1'b1;
                        rd_data_d[7:0]            = fifo_dout;
                    end
                end
                REG_STAT: rd_data_d = stat_word;
                REG_CTRL: rd_data_d = {15'b0, irq_en_q};
                default:  rd_data_d = rd_data_q;
            endcase
        end

        irq_d = irq_en_q & (~fifo_empty | ovr_q);
    end

    // Register state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q <= '0;
            rd_hit_q  <= 1'b0;
            irq_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            rd_hit_q  <= rd_hit_d;
            irq_q     <= irq_d;
            irq_en_q  <= irq_en_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_hit  = rd_hit_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_mmio_ctrl.sv
// Scoreboard bench: reads push expected rd_data, a monitor compares on each rd_hit.
module tb_uart_rx_mmio_ctrl;

    logic        clock;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [15:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_hit;
    logic        irq;

    int checks;
    int failures;
    logic [15:0] exp_q [$];

    uart_rx_mmio_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .addr     (addr),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .rd_hit   (rd_hit),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every decoded read response is matched against the scoreboard.
    always @(negedge clock) begin
        if (rd_hit === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rd_hit: got %h expected no response", rd_data);
            end else begin
                chk("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        addr  = a;
        rd_en = 1'b1;
        exp_q.push_back(e);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        rx_byte  = '0;
        rx_valid = 1'b0;
        addr     = '0;
        rd_en    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;

        // Reset
        repeat (5) tick();
        chk("reset_rd_data", rd_data, 16'h0000);
        chk("reset_irq", {15'b0, irq}, 16'h0000);
        chk("reset_rd_hit", {15'b0, rd_hit}, 16'h0000);
        reset = 1'b1;
        tick();
        rd(16'hFF01, 16'h0000);

        // Two bytes, extreme values
        push(8'h00);
        push(8'hFF);
        rd(16'hFF01, 16'h0011);
        rd(16'hFF00, 16'h8000);
        rd(16'hFF00, 16'h80FF);
        rd(16'hFF03, 16'h0000);
        exp_q.pop_back();
        chk("unmapped_hold_data", rd_data, 16'h80FF);
        chk("unmapped_no_hit", {15'b0, rd_hit}, 16'h0000);
        rd(16'hFF00, 16'h0000);

        // Overflow by one
        for (int i = 1; i <= 9; i++) push(8'(i));
        rd(16'hFF01, 16'h0047);
        for (int i = 1; i <= 8; i++) rd(16'hFF00, 16'h8000 | 16'(i));
        rd(16'hFF01, 16'h0004);
        wr(16'hFF01, 16'h0004);
        rd(16'hFF01, 16'h0000);

        // Interrupt follows pending data
        wr(16'hFF02, 16'h0001);
        rd(16'hFF02, 16'h0001);
        push(8'hA5);
        chk("irq_not_yet", {15'b0, irq}, 16'h0000);
        tick();
        chk("irq_rise", {15'b0, irq}, 16'h0001);
        rd(16'hFF00, 16'h80A5);
        chk("irq_hold_at_pop", {15'b0, irq}, 16'h0001);
        tick();
        chk("irq_fall", {15'b0, irq}, 16'h0000);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        rx_byte  = 8'h3C;
        rx_valid = 1'b1;
        rd(16'hFF00, 16'h8010);
        rx_valid = 1'b0;
        rd(16'hFF01, 16'h0043);
        for (int i = 1; i < 8; i++) rd(16'hFF00, 16'h8000 | 16'(8'h10 + i));
        rd(16'hFF00, 16'h803C);
        rd(16'hFF00, 16'h0000);

        // Overrun set beats clear in the same cycle
        for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
        rd(16'hFF01, 16'h0047);
        rx_byte  = 8'h29;
        rx_valid = 1'b1;
        wr(16'hFF01, 16'h0004);
        rx_valid = 1'b0;
        rd(16'hFF01, 16'h0047);
        tick();
        chk("irq_on_overrun", {15'b0, irq}, 16'h0001);

        // Flush beats a simultaneous push
        rx_byte  = 8'h55;
        rx_valid = 1'b1;
        wr(16'hFF02, 16'h0002);
        rx_valid = 1'b0;
        rd(16'hFF01, 16'h0000);
        rd(16'hFF02, 16'h0000);
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        rx_byte  = 8'h66;
        rx_valid = 1'b1;
        wr(16'hFF02, 16'h0002);
        rx_valid = 1'b0;
        rd(16'hFF01, 16'h0000);
        rd(16'hFF00, 16'h0000);
        chk("irq_after_flush", {15'b0, irq}, 16'h0000);

        // Asynchronous reset mid-sequence
        wr(16'hFF02, 16'h0001);
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        rd(16'hFF01, 16'h0019);
        tick();
        chk("irq_before_reset", {15'b0, irq}, 16'h0001);
        chk("rd_data_before_reset", rd_data, 16'h0019);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rd_data", rd_data, 16'h0000);
        chk("async_irq", {15'b0, irq}, 16'h0000);
        tick();
        reset = 1'b1;
        tick();
        rd(16'hFF01, 16'h0000);
        rd(16'hFF02, 16'h0000);
        rd(16'hFF00, 16'h0000);

        repeat (3) tick();
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_mmio_ctrl.md
Name: uart_rx_mmio_ctrl

Overview:
- Memory-mapped controller that sits between the UART receive core and the CPU data bus.
- Buffers each received byte, from the rx core's one-cycle valid pulse, in a small FIFO.
- Exposes data, status and control registers at a fixed base address, tracks overrun, and raises a level interrupt while data is pending.
- Lets the CPU drain UART input at its own pace, decoupled from the 9600-baud line.

Parameters:
- BASE_ADDR, 16'hFF00: word address of the data register; status at BASE_ADDR+1, control at BASE_ADDR+2.
- FIFO_DEPTH, 8: byte entries; must be a power of 2, range 2..64.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of the occupancy count.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-low; 0 clears all state
- rx_byte  in  8  byte from UART rx core
- rx_valid  in  1  one-cycle strobe; rx_byte valid this cycle
- addr  in  16  CPU word address
- rd_en  in  1  CPU read strobe
- wr_en  in  1  CPU write strobe
- wr_data  in  16  CPU write data
- rd_data  out  16  registered read data
- rd_hit  out  1  registered; 1 when rd_data carries this block's register
- irq  out  1  level interrupt

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; pointers and count 0; overrun=0; irq_en=0.
  - rd_data=16'h0000, rd_hit=0, irq=0.
- Address decode: offsets 0/1/2 from BASE_ADDR. Any other address is ignored, and rd_hit=0 next cycle.
- Read latency is 1 cycle. rd_data and rd_hit update on the clock edge after rd_en. rd_data holds its value until the next decoded read.
- Data register (offset 0), read:
  - FIFO non-empty: rd_data={1'b1, 7'b0, head byte}; head is popped in the same edge.
  - FIFO empty: rd_data=16'h0000; no pointer change.
- Data register, write: ignored.
- Status register (offset 1), read: [0] not_empty, [1] full, [2] overrun, [3+CNT_W-1:3] count, rest 0. No side effects.
- Status register, write: wr_data[2]=1 clears overrun. Other bits are ignored.
- Control register (offset 2), read/write:
  - [0] irq_en, read/write.
  - [1] flush, write-only pulse: empties the FIFO and clears overrun. Reads as 0.
- Push: on rx_valid, when not full, write rx_byte at the tail and increment the count.
- Full without a simultaneous pop: rx_byte is dropped, overrun set to 1, FIFO contents unchanged.
- Push and pop in the same cycle:
  - Both take effect and the count is unchanged.
  - When full, the push is accepted and overrun stays as it was.
  - When empty, the read returns 16'h0000 and the pushed byte is stored. There is no bypass.
- Flush and rx_valid in the same cycle: flush wins and the byte is discarded. Overrun stays cleared.
- Overrun set and clear in the same cycle: set wins.
- Wrap-around: pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count runs 0..FIFO_DEPTH; full when count==FIFO_DEPTH.
- irq: registered, irq = irq_en & (not_empty | overrun). It updates the cycle after the underlying state changes.
- rd_en and wr_en both asserted: the write has priority, and the read still returns pre-write register values.
- Reset asserted mid-operation: the asynchronous clear applies immediately and discards any in-flight byte. Do not expect rx_valid before reset releases.

Decomposition:
- Package uart_mmio_pkg holds:
  - offsets DATA_OFS=0, STAT_OFS=1, CTRL_OFS=2;
  - status bit indices ST_NE=0, ST_FULL=1, ST_OVR=2, ST_CNT_LSB=3;
  - control bit indices CT_IRQEN=0, CT_FLUSH=1;
  - DATA_VALID_BIT=15.
- Sub-module byte_fifo (parameter DEPTH):
  - ports push, pop, flush, din[7:0], dout[7:0], count, full, empty;
  - pop is qualified by !empty inside the sub-module.
- uart_rx_mmio_ctrl keeps decode, the overrun/irq logic and the read mux.

Test Plan:
- Reset low for 5 cycles, then high: rd_data=0, irq=0. Status read at 16'hFF01 returns 16'h0000.
- Pulse rx_byte=8'h00, then rx_byte=8'hFF:
  - status reads 16'h0011 (count=2, not_empty);
  - data reads return 16'h8000 then 16'h80FF;
  - a third data read returns 16'h0000.
- Push 9 bytes 8'h01..8'h09 with FIFO_DEPTH=8:
  - status reads 16'h0047 (count=8, overrun, full, ne);
  - 8 pops return 8'h01..8'h08;
  - writing 16'h0004 to 16'hFF01 clears overrun.
- Write 16'h0001 to 16'hFF02, then push 8'hA5: irq rises 1 cycle after rx_valid. Popping 8'hA5 drops irq the cycle after the pop.
- With FIFO full, a simultaneous rx_valid (8'h3C) and data read: the read returns the oldest byte, count stays 8, overrun stays 0, and 8'h3C comes out last after 7 more pops.
- Write 16'h0002 to 16'hFF02 with 5 bytes queued and rx_valid in the same cycle: status reads 16'h0000 afterwards. Repeat with reset pulsed low mid-sequence: state clears immediately, without waiting for a clock edge.
